aes128_mode_ctrl: RTL and testbench

//  Block-cipher mode controller sitting directly upstream of aes128_cipher_top.

---
 rtl/aes128_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aes128_mode_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_mode_ctrl.sv
// ECB/CBC/CTR chaining controller in front of aes128_cipher_top; one block in flight.
// Define AES128_MODE_CTR_EN to build the CTR datapath and counter incrementer.
module aes128_mode_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [1:0]   mode_sel,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic [127:0] core_plain_text,
  output logic         core_cipher_en,
  input  logic [127:0] core_cipher_text,
  input  logic         core_cipher_ready
);

  // state   | meaning
  // S_IDLE  | waiting for an iv_load or an input block
  // S_START | pulse core_cipher_en for one cycle
  // S_WAIT  | waiting for core_cipher_ready, then capture result
  // S_DONE  | presenting out_data until out_ready

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   mode;
  logic [1:0]   mode_dec;
  logic [127:0] chain;
  logic [127:0] chain_nxt;
  logic [127:0] plain_nxt;
  logic [127:0] result_nxt;
  logic         accept_iv;
  logic         accept_blk;
  logic         capture;

  if (CTR_W < 1 || CTR_W > 127) begin : g_bad_ctr_w
    $error("CTR_W must lie in 1..127");
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    core_cipher_en = 1'b0;
    busy           = 1'b1;
    accept_iv      = 1'b0;
    accept_blk     = 1'b0;
    capture        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (!rst) begin
          if (iv_load) begin
            accept_iv = 1'b1;
          end else begin
            in_ready = 1'b1;
            if (in_valid) begin
              accept_blk = 1'b1;
              state_nxt  = S_START;
            end
          end
        end
      end
      S_START: begin
        core_cipher_en = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (core_cipher_ready) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Unsupported encodings collapse to ECB at load time so the datapath never sees them.
  always_comb begin
    mode_dec = MODE_ECB;
    case (mode_sel)
      MODE_CBC: mode_dec = MODE_CBC;
`ifdef AES128_MODE_CTR_EN
      MODE_CTR: mode_dec = MODE_CTR;
`endif
      default:  mode_dec = MODE_ECB;
    endcase
  end

`ifdef AES128_MODE_CTR_EN
  logic [127:0]     data_lat;
  logic [CTR_W-1:0] ctr_inc;

  assign ctr_inc = chain[CTR_W-1:0] + CTR_W'(1);

  always_ff @(posedge clk_sys) begin
    if (rst)             data_lat <= '0;
    else if (accept_blk) data_lat <= in_data;
  end
`endif

  always_comb begin
    plain_nxt  = in_data;
    result_nxt = core_cipher_text;
    chain_nxt  = chain;
    case (mode)
      MODE_CBC: begin
        plain_nxt = in_data ^ chain;
        chain_nxt = core_cipher_text;
      end
`ifdef AES128_MODE_CTR_EN
      MODE_CTR: begin
        plain_nxt  = chain;
        result_nxt = data_lat ^ core_cipher_text;
        chain_nxt  = {chain[127:CTR_W], ctr_inc};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mode            <= MODE_ECB;
      chain           <= '0;
      core_plain_text <= '0;
      out_data        <= '0;
    end else begin
      if (accept_iv) begin
        mode  <= mode_dec;
        chain <= iv;
      end
      if (accept_blk) core_plain_text <= plain_nxt;
      if (capture) begin
        out_data <= result_nxt;
        chain    <= chain_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes128_mode_ctrl.sv
// Scoreboard bench for aes128_mode_ctrl with a behavioural cipher core stand-in.
// The stand-in returns the published AES-128 result for the reference plaintext and a keyed scramble otherwise.
module tb_aes128_mode_ctrl;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CTR_IV = 128'h00112233445566778899aabbffffffff;
  localparam int           LAT    = 3;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic [1:0]   mode_sel;
  logic         iv_load;
  logic [127:0] iv;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready;
  logic         busy;
  logic [127:0] core_plain_text;
  logic         core_cipher_en;
  logic [127:0] core_cipher_text;
  logic         core_cipher_ready;

  logic         model_rdy;
  logic [127:0] model_ct;
  logic [127:0] model_pt;
  int           model_cnt;
  int           en_cnt;
  logic         inject_rdy;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q[$];
  string        tag_q[$];
  logic [127:0] prev_out, last_out;

  logic [1:0]   tb_mode;
  logic [127:0] tb_chain;

  always #5 clk_sys = ~clk_sys;

  aes128_mode_ctrl #(.CTR_W(32)) dut (
    .clk_sys           (clk_sys),
    .rst               (rst),
    .mode_sel          (mode_sel),
    .iv_load           (iv_load),
    .iv                (iv),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .busy              (busy),
    .core_plain_text   (core_plain_text),
    .core_cipher_en    (core_cipher_en),
    .core_cipher_text  (core_cipher_text),
    .core_cipher_ready (core_cipher_ready)
  );

  function automatic logic [127:0] core_f(input logic [127:0] x);
    if (x == PT) return CT;
    return {x[94:0], x[127:95]} ^ 128'hc3a5_5a3c_0f1e_2d4b_9687_7869_e1d2_b4f0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cipher core stand-in; it resets with the controller as the real core would.
  always @(posedge clk_sys) begin
    model_rdy <= 1'b0;
    if (rst) begin
      model_cnt <= 0;
    end else if (core_cipher_en) begin
      model_cnt <= LAT;
      model_pt  <= core_plain_text;
      en_cnt    <= en_cnt + 1;
    end else if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      if (model_cnt == 1) begin
        model_rdy <= 1'b1;
        model_ct  <= core_f(model_pt);
      end
    end
  end

  assign core_cipher_ready = model_rdy | inject_rdy;
  assign core_cipher_text  = model_rdy ? model_ct : 128'hdead_beef_dead_beef_dead_beef_dead_beef;

  always @(negedge clk_sys) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1'b1, 1'b0);
      end else begin
        check(tag_q.pop_front(), out_data, exp_q.pop_front());
        prev_out = last_out;
        last_out = out_data;
      end
    end
  end

  task automatic model_load(input logic [1:0] m, input logic [127:0] v);
    tb_chain = v;
    tb_mode  = m;
    if (m == 2'b11) tb_mode = 2'b00;
`ifndef AES128_MODE_CTR_EN
    if (m == 2'b10) tb_mode = 2'b00;
`endif
  endtask

  task automatic push_exp(input logic [127:0] d, input string tag);
    logic [127:0] e;
    case (tb_mode)
      2'b01: begin
        e = core_f(d ^ tb_chain);
        tb_chain = e;
      end
      2'b10: begin
        e = d ^ core_f(tb_chain);
        tb_chain[31:0] = tb_chain[31:0] + 32'd1;
      end
      default: e = core_f(d);
    endcase
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic load_iv(input logic [1:0] m, input logic [127:0] v);
    iv_load = 1'b1; mode_sel = m; iv = v;
    @(posedge clk_sys); #1;
    iv_load = 1'b0;
    model_load(m, v);
  endtask

  task automatic send_block(input logic [127:0] d, input string tag);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_sys);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk_sys); #1;
    in_valid = 1'b0;
    if (ok) push_exp(d, tag);
    else    check({tag, "_accept_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_sys);
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check({tag, "_idle_timeout"}, 1'b0, 1'b1);
    @(posedge clk_sys); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] d0;
    int           e0;
    bit           seen;
    rst = 1'b1; mode_sel = 2'b00; iv_load = 1'b0; iv = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; inject_rdy = 1'b0;
    en_cnt = 0; model_cnt = 0; model_rdy = 1'b0; model_ct = '0; model_pt = '0;
    prev_out = '0; last_out = '0;
    model_load(2'b00, '0);

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_core_en", core_cipher_en, 1'b0);
    check("rst_core_pt", core_plain_text, '0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk_sys); #1;
    rst = 1'b0;

    // ECB reference vector
    e0 = en_cnt;
    send_block(PT, "ecb_vector");
    wait_idle("ecb");
    check("ecb_en_pulses", 128'(en_cnt - e0), 128'd1);

    // CBC, zero IV, two identical blocks
    load_iv(2'b01, '0);
    send_block(PT, "cbc_blk1");
    send_block(PT, "cbc_blk2");
    wait_idle("cbc");
    check("cbc_blocks_differ", prev_out != last_out, 1'b1);

    // reserved mode behaves as ECB even with a nonzero IV
    load_iv(2'b11, 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef);
    send_block(PT, "rsvd_as_ecb");
    wait_idle("rsvd");

`ifdef AES128_MODE_CTR_EN
    load_iv(2'b10, CTR_IV);
    send_block('0, "ctr_blk1");
    send_block('0, "ctr_blk2_wrapped");
    send_block(PT, "ctr_blk3");
    wait_idle("ctr");
`else
    load_iv(2'b10, CTR_IV);
    send_block(PT, "mode10_as_ecb");
    wait_idle("mode10");
`endif

    // iv_load and in_valid together: IV wins, block taken next cycle
    iv_load = 1'b1; mode_sel = 2'b01; iv = 128'hfeed_face_cafe_f00d_0bad_beef_1234_5678;
    in_valid = 1'b1; in_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(negedge clk_sys);
    check("ivld_collide_in_ready", in_ready, 1'b0);
    @(posedge clk_sys); #1;
    iv_load = 1'b0;
    model_load(2'b01, 128'hfeed_face_cafe_f00d_0bad_beef_1234_5678);
    @(negedge clk_sys);
    check("ivld_next_in_ready", in_ready, 1'b1);
    @(posedge clk_sys); #1;
    in_valid = 1'b0;
    push_exp(128'h1111_2222_3333_4444_5555_6666_7777_8888, "ivld_block");
    wait_idle("ivld");

    // iv_load while busy is ignored: chain and CBC mode must survive
    send_block(PT, "busy_iv_blk1");
    iv_load = 1'b1; mode_sel = 2'b00; iv = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
    @(posedge clk_sys); #1;
    iv_load = 1'b0;
    wait_idle("busy_iv1");
    send_block(PT, "busy_iv_blk2");
    wait_idle("busy_iv2");

    // stray core_cipher_ready in IDLE
    inject_rdy = 1'b1;
    @(posedge clk_sys); #1;
    inject_rdy = 1'b0;
    @(negedge clk_sys);
    check("stray_rdy_busy", busy, 1'b0);
    check("stray_rdy_out_valid", out_valid, 1'b0);
    @(posedge clk_sys); #1;

    // backpressure for 20 cycles
    load_iv(2'b00, '0);
    out_ready = 1'b0;
    send_block(128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, "bp_block");
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_sys);
      if (out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid_seen", seen, 1'b1);
    d0 = out_data;
    e0 = en_cnt;
    for (int n = 0; n < 20; n++) begin
      check("bp_out_valid_held", out_valid, 1'b1);
      check("bp_out_data_held", out_data, d0);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_no_new_en", 128'(en_cnt), 128'(e0));
      @(negedge clk_sys);
    end
    @(posedge clk_sys); #1;
    out_ready = 1'b1;
    wait_idle("bp");

    // reset while in WAIT abandons the block
    load_iv(2'b01, 128'h9999_8888_7777_6666_5555_4444_3333_2222);
    in_valid = 1'b1; in_data = PT;
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_sys);
      if (in_ready) begin seen = 1'b1; break; end
    end
    check("rstw_accept", seen, 1'b1);
    @(posedge clk_sys); #1;
    in_valid = 1'b0;
    @(posedge clk_sys); #1;
    rst = 1'b1;
    @(posedge clk_sys); #1;
    rst = 1'b0;
    model_load(2'b00, '0);
    @(negedge clk_sys);
    check("rstw_busy", busy, 1'b0);
    check("rstw_out_valid", out_valid, 1'b0);
    check("rstw_out_data", out_data, '0);
    repeat (10) @(negedge clk_sys);
    check("rstw_stays_idle", busy, 1'b0);
    @(posedge clk_sys); #1;
    send_block(PT, "ecb_after_rst");
    wait_idle("ecb_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
